mem_port_arb: RTL and testbench
===============================

# mem_port_arb

Shares one single-port memory between the instruction-fetch stage (read-only) and the data-memory stage (load/store) of the pipelined core. Arbitrates requests, drives the shared memory port, counts fixed memory latency, routes read data back to the owner and generates per-requester stall. Sits between the IF/MEM stages and the unified memory model, replacing separate imem/dmem ports.

## Interface
- MEM_LAT, 1: cycles from issue to valid `m_rdata`; legal 1..7.
- STARVE_MAX, 4: consecutive fetch losses before fetch is forced to win; legal 1..15. Used only with the guard compiled in.

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until `if_ack`
- if_addr  in  32  fetch byte address, stable while `if_req`
- if_rdata  out  32  instruction word, valid with `if_ack`
- if_ack  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  `if_req && !if_ack`; drives IF `if_stall`
- d_req  in  1  data request, held until `d_ack`
- d_we  in  1  1 = store
- d_be  in  4  byte enables for stores
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid with `d_ack`
- d_ack  out  1  one-cycle completion pulse for data
- d_stall  out  1  `d_req && !d_ack`
- m_req  out  1  issue strobe to memory, one cycle per transaction
- m_we  out  1  write enable
- m_be  out  4  byte enables; 4'hF on fetch
- m_addr  out  32  address
- m_wdata  out  32  write data; 0 on fetch
- m_rdata  in  32  read data, valid MEM_LAT cycles after `m_req`

## Operation
- FSM states: IDLE, BUSY. Owner register: OWN_IF, OWN_D. One transaction outstanding at most.
- IDLE: if any request, pick winner combinationally, assert `m_req` and drive `m_*` from winner in the same cycle; load latency counter with MEM_LAT; go BUSY, latch owner.
- Default priority: data over fetch (MEM is the older instruction).
- BUSY: counter decrements each cycle; when counter reaches 1 at a clock edge, the following cycle is the return cycle: pulse owner's `_ack`, drive owner's `_rdata` = `m_rdata`; next state IDLE. No issue in the return cycle.
- Non-owner `_rdata` = 0. `_ack` never asserted without a matching issue.
- Stores ack after MEM_LAT cycles like loads; `d_rdata` = `m_rdata` (don't-care to core).
- Requester dropping `req` before ack: illegal; transaction still completes, ack pulse still issued.
- `m_*` outputs other than `m_req` are 0 when `m_req` = 0.

## Timing
- Reset values: state IDLE, owner OWN_IF, counter 0, starve counter 0; all outputs 0 while `rst` high.
- Reset mid-transaction: in-flight transaction abandoned, no ack, IDLE next cycle.
- Latency: request seen in IDLE cycle T -> `m_req` at T -> ack at T+MEM_LAT. Next issue earliest T+MEM_LAT+1. Throughput one transaction per MEM_LAT+1 cycles.
- Simultaneous `if_req`/`d_req` in IDLE: data issued at T, fetch at T+MEM_LAT+1 (guard permitting).
- Stall is combinational from `req` and `ack`; low exactly in the ack cycle.

## Configuration
- MEM_PORT_ARB_STARVE_GUARD_EN defined: 4-bit counter increments each IDLE arbitration where both request and data wins; when counter == STARVE_MAX, fetch wins that arbitration and counter clears; any fetch grant clears it.
- Undefined: fixed data-over-fetch priority, no counter, STARVE_MAX ignored.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, BUSY), owner enum (OWN_IF, OWN_D), `LAT_W` = 3, NOP-independent constant `BE_ALL` = 4'hF.
- Sub-module `arb_lat_cnt`: loadable down-counter (load, value, done), reused for latency counting.

## Test plan
- Reset: `rst` 3 cycles with both `req` high -> `m_req`, `if_ack`, `d_ack` stay 0; first issue the cycle after `rst` falls.
- Lone fetch, MEM_LAT=2, `if_addr`=0x100, `m_rdata`=0x00000013 -> `m_req` at T, `if_ack`+`if_rdata`=0x13 at T+2, `if_stall` high T..T+1.
- Conflict, MEM_LAT=1: both req at T -> data issued T, acked T+1; fetch issued T+2, acked T+3.
- Store: `d_we`=1, `d_be`=4'b0011, `d_addr`=0x2004, `d_wdata`=0xCAFE -> `m_we`=1, `m_be`=0011, `m_addr`=0x2004 for one cycle; `d_ack` at T+MEM_LAT.
- Guard on, STARVE_MAX=2, both req held continuously -> grant order D, D, IF, D, D, IF; guard off -> IF never granted.
- Reset asserted at T+1 of a MEM_LAT=3 fetch -> no `if_ack` ever for it; clean re-issue after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

   localparam int unsigned LAT_W  = 3;
   localparam logic [3:0]  BE_ALL = 4'hF;

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter; done flags the cycle in which the count sits at 1.
module arb_lat_cnt #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between fetch and data stages, one transaction in flight.
// Optional fetch starvation guard enabled by defining MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_stall,
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
   localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   owner_t     owner;
   logic       lat_done;
   logic       issue;
   logic       ret;
   logic       pick_if;
   logic [3:0] starve;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;

   // Counts consecutive arbitrations where fetch was waiting but data won.
   always_ff @(posedge clk) begin
      if (rst)
         starve <= '0;
      else if (issue) begin
         if (pick_if)
            starve <= '0;
         else if (if_req)
            starve <= starve + 4'd1;
      end
   end
`else
   localparam bit GUARD = 1'b0;
   assign starve = '0;
`endif

   always_comb begin
      pick_if = if_req && (!d_req || (GUARD && (starve == STARVE_LIM)));
      issue   = !rst && (state == IDLE) && (if_req || d_req);
      ret     = !rst && (state == BUSY) && lat_done;
   end

   arb_lat_cnt #(.W(LAT_W)) u_lat (
      .clk   (clk),
      .rst   (rst),
      .load  (issue),
      .value (LAT_LOAD),
      .done  (lat_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_IF;
      end else begin
         case (state)
            IDLE: if (issue) begin
               state <= BUSY;
               owner <= pick_if ? OWN_IF : OWN_D;
            end
            BUSY: if (lat_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_req   = issue;
      m_we    = 1'b0;
      m_be    = '0;
      m_addr  = '0;
      m_wdata = '0;
      if (issue) begin
         if (pick_if) begin
            m_be   = BE_ALL;
            m_addr = if_addr;
         end else begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
         end
      end
      if_ack   = ret && (owner == OWN_IF);
      d_ack    = ret && (owner == OWN_D);
      if_rdata = if_ack ? m_rdata : '0;
      d_rdata  = d_ack ? m_rdata : '0;
      if_stall = !rst && if_req && !if_ack;
      d_stall  = !rst && d_req && !d_ack;
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed sequences, a vector table and
// randomized traffic against a cycle-count based reference model.
module tb_mem_port_arb;

   localparam int unsigned LAT  = 2;
   localparam int unsigned SMAX = 2;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [3:0]  d_be;
   logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
   logic        if_ack, if_stall, d_ack, d_stall, m_req, m_we;
   logic [3:0]  m_be;

   mem_port_arb #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the pending return is tracked as an absolute cycle number.
   int cyc    = 0;
   int ret_at = -1;
   bit own_d  = 1'b0;
   int starve = 0;
   bit g_if;

   logic        e_m_req, e_m_we, e_if_ack, e_if_stall, e_d_ack, e_d_stall;
   logic [3:0]  e_m_be;
   logic [31:0] e_m_addr, e_m_wdata, e_if_rdata, e_d_rdata;

   logic        s_m_req, s_m_we, s_if_ack, s_if_stall, s_d_ack, s_d_stall;
   logic [3:0]  s_m_be;
   logic [31:0] s_m_addr, s_m_wdata, s_if_rdata, s_d_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_eval();
      {e_m_req, e_m_we, e_if_ack, e_if_stall, e_d_ack, e_d_stall} = '0;
      e_m_be = '0; e_m_addr = '0; e_m_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
      g_if = 1'b0;
      if (!rst) begin
         if (ret_at == cyc) begin
            if (own_d) begin e_d_ack = 1'b1; e_d_rdata = m_rdata; end
            else begin e_if_ack = 1'b1; e_if_rdata = m_rdata; end
         end else if (ret_at < cyc && (if_req || d_req)) begin
            g_if = if_req && (!d_req || (GUARD && starve == int'(SMAX)));
            e_m_req = 1'b1;
            if (g_if) begin
               e_m_be = 4'hF; e_m_addr = if_addr;
            end else begin
               e_m_we = d_we; e_m_be = d_be; e_m_addr = d_addr; e_m_wdata = d_wdata;
            end
         end
         e_if_stall = if_req && !e_if_ack;
         e_d_stall  = d_req && !e_d_ack;
      end
   endtask

   task automatic model_update();
      if (rst) begin
         ret_at = -1;
         starve = 0;
      end else if (e_m_req) begin
         ret_at = cyc + int'(LAT);
         own_d  = !g_if;
         if (g_if) starve = 0;
         else if (if_req) starve++;
      end
      cyc++;
   endtask

   task automatic step();
      model_eval();
      @(negedge clk);
      s_m_req = m_req; s_m_we = m_we; s_m_be = m_be; s_m_addr = m_addr; s_m_wdata = m_wdata;
      s_if_ack = if_ack; s_if_rdata = if_rdata; s_if_stall = if_stall;
      s_d_ack = d_ack; s_d_rdata = d_rdata; s_d_stall = d_stall;
      chk("m_req", s_m_req, e_m_req);
      chk("m_we", s_m_we, e_m_we);
      chk("m_be", s_m_be, e_m_be);
      chk("m_addr", s_m_addr, e_m_addr);
      chk("m_wdata", s_m_wdata, e_m_wdata);
      chk("if_ack", s_if_ack, e_if_ack);
      chk("if_rdata", s_if_rdata, e_if_rdata);
      chk("if_stall", s_if_stall, e_if_stall);
      chk("d_ack", s_d_ack, e_d_ack);
      chk("d_rdata", s_d_rdata, e_d_rdata);
      chk("d_stall", s_d_stall, e_d_stall);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && (if_req || d_req); c++) begin
         step();
         if (s_if_ack) if_req = 1'b0;
         if (s_d_ack)  d_req  = 1'b0;
      end
      chk("drain_done", {if_req, d_req}, 2'b00);
   endtask

   typedef struct {
      bit          fetch;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr, wdata, rdata;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr, exp_wdata, exp_rdata;
   } vec_t;

   vec_t vecs[4];
   bit   exp_grant[6];
   bit   grants[6];
   int   n;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 4'b0011, 32'h2004, 32'hCAFE, 32'hDEAD_BEEF,
                  1'b1, 4'b0011, 32'h2004, 32'hCAFE, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h0100, 32'h5555, 32'h0000_0013,
                  1'b0, 4'hF, 32'h0100, 32'h0, 32'h0000_0013};
      vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h3000, 32'h1234, 32'h8765_4321,
                  1'b0, 4'hF, 32'h3000, 32'h1234, 32'h8765_4321};
      vecs[3] = '{1'b0, 1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,
                  1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0};
      for (int i = 0; i < 6; i++) begin
         exp_grant[i] = GUARD && (i % 3 == 2);
         grants[i] = 1'b0;
      end

      rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
      if_addr = 32'h1000; d_addr = 32'h2000; d_wdata = 32'h0; m_rdata = 32'h0;
      @(posedge clk); #1;

      // Reset held with both requests pending, then continuous contention.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_m_req", s_m_req, 1'b0);
         chk("rst_acks", {s_if_ack, s_d_ack}, 2'b00);
      end
      rst = 1'b0;
      n = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         step();
         if (c == 0) chk("first_issue", s_m_req, 1'b1);
         if (s_m_req) begin
            grants[n] = (s_m_addr == 32'h1000);
            n++;
         end
      end
      chk("grant_count", n, 6);
      for (int i = 0; i < 6; i++) chk("grant_order", grants[i], exp_grant[i]);
      drain();

      // Lone fetch.
      do_reset();
      if_addr = 32'h100; if_req = 1'b1;
      step();
      chk("fetch_issue", s_m_req, 1'b1);
      chk("fetch_addr", s_m_addr, 32'h100);
      chk("fetch_be", s_m_be, 4'hF);
      chk("fetch_stall", s_if_stall, 1'b1);
      for (int k = 1; k < int'(LAT); k++) begin
         step();
         chk("fetch_wait_stall", s_if_stall, 1'b1);
         chk("fetch_wait_ack", s_if_ack, 1'b0);
      end
      m_rdata = 32'h13;
      step();
      chk("fetch_ack", s_if_ack, 1'b1);
      chk("fetch_rdata", s_if_rdata, 32'h13);
      chk("fetch_stall_ack", s_if_stall, 1'b0);
      chk("fetch_no_issue_ret", s_m_req, 1'b0);
      if_req = 1'b0; m_rdata = $urandom;
      step();
      chk("idle_quiet", s_m_req, 1'b0);

      // Simultaneous requests: data first, fetch right after the data return.
      do_reset();
      if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; d_be = 4'hF;
      if_req = 1'b1; d_req = 1'b1;
      step();
      chk("conf_d_addr", s_m_addr, 32'h2000);
      for (int k = 1; k < int'(LAT); k++) step();
      step();
      chk("conf_d_ack", {s_d_ack, s_if_ack}, 2'b10);
      d_req = 1'b0;
      step();
      chk("conf_if_issue", s_m_req, 1'b1);
      chk("conf_if_addr", s_m_addr, 32'h1000);
      for (int k = 1; k < int'(LAT); k++) step();
      step();
      chk("conf_if_ack", {s_if_ack, s_d_ack}, 2'b10);
      if_req = 1'b0;
      step();

      // Vector table: one isolated transaction per record.
      for (int i = 0; i < 4; i++) begin
         do_reset();
         if_req  = vecs[i].fetch;
         d_req   = !vecs[i].fetch;
         if_addr = vecs[i].fetch ? vecs[i].addr : 32'hAAAA_0000;
         d_addr  = vecs[i].fetch ? 32'hBBBB_0000 : vecs[i].addr;
         d_we = vecs[i].we; d_be = vecs[i].be; d_wdata = vecs[i].wdata;
         step();
         chk("vec_m_req", s_m_req, 1'b1);
         chk("vec_m_we", s_m_we, vecs[i].exp_we);
         chk("vec_m_be", s_m_be, vecs[i].exp_be);
         chk("vec_m_addr", s_m_addr, vecs[i].exp_addr);
         chk("vec_m_wdata", s_m_wdata, vecs[i].exp_wdata);
         for (int k = 1; k < int'(LAT); k++) begin
            step();
            chk("vec_busy", s_m_req, 1'b0);
         end
         m_rdata = vecs[i].rdata;
         step();
         chk("vec_ack", {s_if_ack, s_d_ack}, vecs[i].fetch ? 2'b10 : 2'b01);
         chk("vec_rdata", vecs[i].fetch ? s_if_rdata : s_d_rdata, vecs[i].exp_rdata);
         chk("vec_other_rdata", vecs[i].fetch ? s_d_rdata : s_if_rdata, 32'h0);
         if_req = 1'b0; d_req = 1'b0; m_rdata = $urandom;
         step();
      end

      // Reset one cycle after a fetch issue: the fetch is abandoned and reissued.
      do_reset();
      if_addr = 32'h400; if_req = 1'b1;
      step();
      chk("rmid_issue", s_m_req, 1'b1);
      rst = 1'b1;
      step();
      chk("rmid_rst_ack", s_if_ack, 1'b0);
      rst = 1'b0;
      step();
      chk("rmid_reissue", s_m_req, 1'b1);
      chk("rmid_no_ack", s_if_ack, 1'b0);
      for (int k = 1; k < int'(LAT); k++) begin
         step();
         chk("rmid_wait", s_if_ack, 1'b0);
      end
      step();
      chk("rmid_ack", s_if_ack, 1'b1);
      if_req = 1'b0;
      step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!if_req || e_if_ack) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
         end
         if (!d_req || e_d_ack) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1);
            d_be    = 4'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         m_rdata = $urandom;
         step();
      end
      rst = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
